mode_power_decoder: RTL and testbench

//   Decodes the 8-bit channel configuration byte of the Smart House controller

---
 rtl/mode_power_decoder.sv | 83 ++++++++
 tb/tb_mode_power_decoder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mode_power_decoder.sv
// -----------------------------------------------------------------------------
// mode_power_decoder
//
// Purpose:
//   Decodes the 8-bit channel configuration byte into a registered operating
//   mode flag and a 4-bit power level for the channel power drivers. It applies
//   the eco-mode power cap and the global power ceiling. The result saturates
//   and never wraps.
//
// Optional feature (macro CHS_RAMP_EN):
//   undefined : chs_power follows the clamped target one cycle after sampling.
//   defined   : chs_power slews by exactly one step per cycle toward the
//               clamped target and redirects whenever the target changes.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   chs_conf   in   8  [7]=mode (1=eco), [6:4]=reserved/ignored, [3:0]=requested power
//   chs_power  out  4  registered power level
//   chs_mode   out  1  registered mode: 0=normal, 1=eco
//
// Parameters:
//   MAX_POWER  global ceiling on chs_power in any mode
//   ECO_MAX    ceiling on chs_power while in eco mode (expected <= MAX_POWER)
// -----------------------------------------------------------------------------
module mode_power_decoder #(
    parameter logic [3:0] MAX_POWER = 4'd15,
    parameter logic [3:0] ECO_MAX   = 4'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] chs_conf,
    output logic [3:0] chs_power,
    output logic       chs_mode
);

    // The eco ceiling is also limited by MAX_POWER, so a mis-set ECO_MAX can
    // never lift power above the global limit.
    localparam logic [3:0] ECO_CAP = (ECO_MAX < MAX_POWER) ? ECO_MAX : MAX_POWER;

    logic [3:0] req;
    logic [3:0] cap;
    logic [3:0] tgt;

    logic [3:0] power_d, power_q;
    logic       mode_d,  mode_q;

    always_comb begin
        req = chs_conf[3:0];
        cap = chs_conf[7] ? ECO_CAP : MAX_POWER;
        tgt = (req > cap) ? cap : req;
    end

    always_comb begin
        mode_d = chs_conf[7];
`ifdef CHS_RAMP_EN
        // The slew runs from the current output toward the newest target.
        // Old targets are not queued, so a change mid-ramp turns the ramp around.
        power_d = power_q;
        if (power_q < tgt) begin
            power_d = power_q + 4'd1;
        end else if (power_q > tgt) begin
            power_d = power_q - 4'd1;
        end
`else
        power_d = tgt;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            power_q <= 4'd0;
            mode_q  <= 1'b0;
        end else begin
            power_q <= power_d;
            mode_q  <= mode_d;
        end
    end

    assign chs_power = power_q;
    assign chs_mode  = mode_q;

endmodule

// File: tb/tb_mode_power_decoder.sv
module tb_mode_power_decoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] chs_conf;
    logic [3:0] chs_power;
    logic       chs_mode;

    mode_power_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .chs_conf  (chs_conf),
        .chs_power (chs_power),
        .chs_mode  (chs_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] conf;
        logic [3:0] power;
        logic       mode;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_vec    = 0;

    task automatic check(input string name, input logic [3:0] ap, input logic am,
                         input logic [3:0] ep, input logic em);
        n_checks++;
        if (ap !== ep || am !== em) begin
            n_fail++;
            $display("FAIL %s: got power=%0d mode=%0d, expected power=%0d mode=%0d",
                     name, ap, am, ep, em);
        end
    endtask

    // Drive one configuration byte ahead of the next rising edge and record
    // what the outputs must show after that edge; returns on the next falling edge.
    task automatic apply(input logic [7:0] c, input logic [3:0] p, input logic m);
        exp_t e;
        e.conf  = c;
        e.power = p;
        e.mode  = m;
        chs_conf = c;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: the DUT presents a new output after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                check($sformatf("vec%0d conf=%02h", n_vec, e.conf),
                      chs_power, chs_mode, e.power, e.mode);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        chs_conf = 8'hFF;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", chs_power, chs_mode, 4'd0, 1'b0);

        // Release mid-cycle: outputs must hold until the first rising edge.
        rst_n = 1'b1;
        #1;
        check("hold_after_release", chs_power, chs_mode, 4'd0, 1'b0);

`ifndef CHS_RAMP_EN
        apply(8'hFF, 4'd7,  1'b1);
        apply(8'h0F, 4'd15, 1'b0);
        apply(8'h6E, 4'd14, 1'b0);
        apply(8'h0A, 4'd10, 1'b0);
        apply(8'h87, 4'd7,  1'b1);
        apply(8'hFF, 4'd7,  1'b1);
        apply(8'hBE, 4'd7,  1'b1);
        apply(8'h7E, 4'd14, 1'b0);
        apply(8'h0F, 4'd15, 1'b0);
        apply(8'h00, 4'd0,  1'b0);
        apply(8'h39, 4'd9,  1'b0);
        for (int r = 0; r < 8; r++) begin
            apply({1'b0, 3'(r), 4'h9}, 4'd9, 1'b0);
            apply({1'b1, 3'(r), 4'h3}, 4'd3, 1'b1);
        end
        apply(8'h88, 4'd7,  1'b1);
        apply(8'h86, 4'd6,  1'b1);
        apply(8'h80, 4'd0,  1'b1);
        apply(8'h01, 4'd1,  1'b0);
        apply(8'h0F, 4'd15, 1'b0);
        apply(8'h8F, 4'd7,  1'b1);
`else
        // Ramp from 0 toward 15 with an eco byte still on the bus for the first
        // edge: target is 7 there, so the first step is 1.
        apply(8'hFF, 4'd1, 1'b1);
        for (int k = 2; k <= 15; k++) apply(8'h0F, 4'(k), 1'b0);
        apply(8'h6E, 4'd14, 1'b0);
        for (int k = 13; k >= 10; k--) apply(8'h0A, 4'(k), 1'b0);
        apply(8'h87, 4'd9, 1'b1);
        apply(8'hFF, 4'd8, 1'b1);
        apply(8'hBE, 4'd7, 1'b1);
        apply(8'hBE, 4'd7, 1'b1);
        for (int k = 8; k <= 14; k++) apply(8'h7E, 4'(k), 1'b0);
        apply(8'h0F, 4'd15, 1'b0);
        // Redirect mid-ramp.
        apply(8'h00, 4'd14, 1'b0);
        apply(8'h00, 4'd13, 1'b0);
        apply(8'h00, 4'd12, 1'b0);
        apply(8'h0F, 4'd13, 1'b0);
        apply(8'h0F, 4'd14, 1'b0);
        apply(8'h0F, 4'd15, 1'b0);
        for (int k = 14; k >= 0; k--) apply(8'h00, 4'(k), 1'b0);
        apply(8'h00, 4'd0, 1'b0);
        for (int k = 1; k <= 9; k++) apply({1'b0, 3'(k % 8), 4'h9}, 4'(k), 1'b0);
        apply(8'h79, 4'd9, 1'b0);
        apply(8'h09, 4'd9, 1'b0);
        for (int k = 10; k <= 12; k++) apply(8'h0F, 4'(k), 1'b0);
`endif

        // Asynchronous reset in the middle of a low clock phase.
        chs_conf = 8'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_now", chs_power, chs_mode, 4'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_holds_over_edges", chs_power, chs_mode, 4'd0, 1'b0);
        rst_n = 1'b1;
        #1;
        check("hold_after_second_release", chs_power, chs_mode, 4'd0, 1'b0);
`ifndef CHS_RAMP_EN
        apply(8'h0F, 4'd15, 1'b0);
        apply(8'h05, 4'd5,  1'b0);
`else
        for (int k = 1; k <= 3; k++) apply(8'h0F, 4'(k), 1'b0);
`endif

        // Let the monitor drain the remaining expectations, bounded.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
